// File: rtl/gr_bi_pkg.sv
// Shared step-class encodings and Gray decode helper for the gr_bi decoder.
package gr_bi_pkg;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_ERR  = 2'b11;

  // Widest word the helper handles; narrower words are zero-extended, which
  // leaves the low bits of the prefix XOR unaffected.
  localparam int GR_MAX_W = 32;

  // Prefix XOR from the MSB down, done by log2 shift-and-XOR passes so the
  // depth is logarithmic rather than a W-long ripple chain.
  function automatic logic [GR_MAX_W-1:0] gray2bin(input logic [GR_MAX_W-1:0] gv);
    logic [GR_MAX_W-1:0] bv;
    bv = gv;
    for (int s = 1; s < GR_MAX_W; s = s * 2) begin
      bv = bv ^ (bv >> s);
    end
    return bv;
  endfunction

endpackage

// File: rtl/gr2bi_comb.sv
// Combinational Gray-to-binary converter, W bits wide (W <= GR_MAX_W).
module gr2bi_comb
  import gr_bi_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  // Zero-extend into the helper and keep only the low W result bits.
  always_comb begin
    b = W'(gray2bin(GR_MAX_W'(g)));
  end

endmodule

// File: rtl/gr_bi_dec.sv
// Two-stage Gray-to-binary decoder: S1 holds the converted word, S2 holds the
// classified output word. Valid/ready on both sides; S2 is the output register.
module gr_bi_dec
  import gr_bi_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  g,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  b,
  output logic [1:0]    dir,
  output logic          step_err,
  output logic [CW-1:0] err_cnt
);

  logic          s1_v;
  logic [W-1:0]  s1_b;
  logic [W-1:0]  conv_b;
  logic          s2_v;
  logic [W-1:0]  prev_b;
  logic          has_prev;
  logic          s1_load;
  logic          s2_load;
  logic [W-1:0]  diff;
  logic [1:0]    cls;

  gr2bi_comb #(.W(W)) u_conv (
    .g (g),
    .b (conv_b)
  );

  // S2 takes S1's word whenever S2 is empty or its word is leaving this cycle.
  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign in_ready  = !s1_v || !s2_v || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_v;
  assign diff      = s1_b - prev_b;

  // Classify the S1 word against the last word that entered S2 (mod 2^W).
  always_comb begin
    cls = DIR_ERR;
    if (!has_prev) begin
      cls = DIR_HOLD;
    end else if (diff == '0) begin
      cls = DIR_HOLD;
    end else if (diff == W'(1)) begin
      cls = DIR_UP;
    end else if (diff == '1) begin
      cls = DIR_DOWN;
    end
  end

  // S1 register: new word when accepted, otherwise empties as its word moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_b <= '0;
    end else if (s1_load) begin
      s1_v <= 1'b1;
      s1_b <= conv_b;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // S2 register plus step history and error counter; all move only on S2 load.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      b        <= '0;
      dir      <= DIR_HOLD;
      step_err <= 1'b0;
      prev_b   <= '0;
      has_prev <= 1'b0;
      err_cnt  <= '0;
    end else if (s2_load) begin
      s2_v     <= 1'b1;
      b        <= s1_b;
      dir      <= cls;
      step_err <= (cls == DIR_ERR);
      prev_b   <= s1_b;
      has_prev <= 1'b1;
      if ((cls == DIR_ERR) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CW'(1);
      end
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gr_bi_dec.sv
// Scoreboard bench for gr_bi_dec (W=4, CW=8).
module tb_gr_bi_dec;

  localparam int W  = 4;
  localparam int CW = 8;

  typedef struct {
    logic [W-1:0]  b;
    logic [1:0]    dir;
    logic          err;
    logic [CW-1:0] cnt;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  g;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  b;
  logic [1:0]    dir;
  logic          step_err;
  logic [CW-1:0] err_cnt;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_acc = 0;
  bit            lat_chk = 1'b0;
  logic [W-1:0]  m_prev;
  bit            m_has;
  logic [CW-1:0] m_cnt;

  gr_bi_dec #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g         (g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .dir       (dir),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  function automatic logic [W-1:0] gray_of(input int k);
    logic [W-1:0] v;
    v = W'(k);
    return v ^ (v >> 1);
  endfunction

  // Reference model: bin = XOR of all right shifts of g; classify by modular diff.
  task automatic push_exp(input logic [W-1:0] gv);
    exp_t         e;
    logic [W-1:0] bv;
    logic [W-1:0] d;
    bv = '0;
    for (int i = 0; i < W; i++) bv = bv ^ (gv >> i);
    d = bv - m_prev;
    if (!m_has)            e.dir = 2'b00;
    else if (d == 4'd0)    e.dir = 2'b00;
    else if (d == 4'd1)    e.dir = 2'b01;
    else if (d == 4'd15)   e.dir = 2'b10;
    else                   e.dir = 2'b11;
    if (e.dir == 2'b11 && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    e.b   = bv;
    e.err = (e.dir == 2'b11);
    e.cnt = m_cnt;
    e.acc = cyc;
    m_prev = bv;
    m_has  = 1'b1;
    sb.push_back(e);
    n_acc++;
  endtask

  // Output monitor: a transfer seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("extra_word", 32'(b), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("b", 32'(b), 32'(e.b));
        chk("dir", 32'(dir), 32'(e.dir));
        chk("step_err", 32'(step_err), 32'(e.err));
        chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
        if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    m_prev = '0;
    m_has  = 1'b0;
    m_cnt  = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] gv);
    int n;
    n = 0;
    in_valid = 1'b1;
    g = gv;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else push_exp(gv);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] conv_tab[5];
    conv_tab = '{4'b1101, 4'b0010, 4'b1011, 4'b0000, 4'b1000};
    rst = 1'b1; in_valid = 1'b0; g = '0; out_ready = 1'b1;
    m_prev = '0; m_has = 1'b0; m_cnt = '0;
    @(posedge clk);
    do_reset();

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;

    // Conversion, back to back, with latency check
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) send(conv_tab[i]);
    drain();
    lat_chk = 1'b0;

    // Steps
    do_reset();
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0011); send(4'b0001);
    drain();
    chk("steps_err_cnt", 32'(err_cnt), 32'd0);

    // Wrap up and wrap down
    do_reset();
    send(4'b1000); send(4'b0000);
    drain();
    do_reset();
    send(4'b0000); send(4'b1000);
    drain();
    chk("wrap_err_cnt", 32'(err_cnt), 32'd0);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    begin
      int base;
      base = n_acc;
      fork
        begin
          for (int k = 1; k <= 6; k++) send(gray_of(k));
        end
        begin
          for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 3) begin
              chk("stall_b", 32'(b), 32'd1);
              chk("stall_out_valid", 32'(out_valid), 32'd1);
            end
          end
          chk("stall_accepted", 32'(n_acc - base), 32'd2);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
    end
    drain();

    // Saturation
    do_reset();
    for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 4'b0000 : 4'b1111);
    drain();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    repeat (3) @(posedge clk);
    #1 chk("sat_hold", 32'(err_cnt), 32'd255);

    // Reset mid-stream with both stages full
    do_reset();
    send(4'b0000); send(4'b0101);
    drain();
    chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    out_ready = 1'b0;
    send(gray_of(1)); send(gray_of(2));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'b0110);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
